// File: rtl/kf_spike_capture.sv
// Egress capture sink for a Kitten Fabric mesh edge port: accepts spike flits and buffers them in a FIFO for a reader.
// Optional macro KF_CAPTURE_TS_EN stores a per-flit acceptance timestamp alongside each flit.
module kf_spike_capture #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     drop_on_full,
    input  logic [CNT_W-1:0]         cap_limit,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [FLIT_W-1:0]        rd_flit,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         cap_count,
    output logic [15:0]              drop_count,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
`ifdef KF_CAPTURE_TS_EN
    localparam int ENTRY_W = FLIT_W + TS_W;
`else
    localparam int ENTRY_W = FLIT_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               fifo_full, fifo_empty;
    logic               push, pop, drop_evt;
    logic [CNT_W-1:0]   cap_next;
    logic [ENTRY_W-1:0] wr_entry, head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Push/drop decisions are derived without in_ready so the FSM block has no feedback path.
    assign push     = in_valid && !rst && !arm && (state_q == S_RUN) && !fifo_full;
    assign drop_evt = in_valid && !rst && !arm && (state_q == S_RUN) && fifo_full && drop_on_full;
    assign pop      = rd_ready && !fifo_empty && !arm;
    assign cap_next = cap_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        if (!rst && (arm || (state_q != S_RUN) || !fifo_full || drop_on_full)) begin
            in_ready = 1'b1;
        end
        if (arm) begin
            state_d = S_RUN;
        end else if (stop) begin
            state_d = S_IDLE;
        end else if ((state_q == S_RUN) && push && (cap_limit != '0) && (cap_next >= cap_limit)) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cap_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                cap_count <= cap_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_evt && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

`ifdef KF_CAPTURE_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign wr_entry = {ts_q, in_flit};
    assign rd_ts    = head[ENTRY_W-1:FLIT_W];
`else
    assign wr_entry = in_flit;
    assign rd_ts    = '0;
`endif

    // Storage has no reset; occupancy is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign rd_flit    = head[FLIT_W-1:0];
    assign rd_valid   = !fifo_empty;
    assign fill_level = wr_ptr - rd_ptr;
    assign state      = state_q;

endmodule
